// File: rtl/width_check_pkg.sv
// Shared types for the pulse-width check scheduler.
package width_check_pkg;

    // Container widths for result payloads; the top truncates to its own sizes.
    localparam int unsigned WC_CH_W  = 8;
    localparam int unsigned WC_CNT_W = 32;

    typedef enum logic [1:0] {
        ARM     = 2'd0,
        MEASURE = 2'd1,
        DRAIN   = 2'd2
    } wc_state_e;

    typedef struct packed {
        logic [WC_CH_W-1:0]  ch;
        logic [WC_CNT_W-1:0] width;
        logic                ok;
        logic                short_;
        logic                long_;
    } wc_result_t;

endpackage

// File: rtl/rr_channel_ptr.sv
// Modulo-N wrapping channel pointer, advanced by a one-cycle strobe.
module rr_channel_ptr #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         adv,
    output logic [W-1:0] ptr
);

    // Pointer register: wraps from N-1 back to 0 on advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= (ptr == W'(N - 1)) ? '0 : ptr + W'(1);
        end
    end

endmodule

// File: rtl/width_check_scheduler.sv
// Round-robin pulse-width checker: one measurement engine shared across N_CH levels.
module width_check_scheduler
    import width_check_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned MIN_CKS     = 1,
    parameter int unsigned MAX_CKS     = 4,
    parameter int unsigned ARM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16,
    localparam int unsigned CH_W       = $clog2(N_CH),
    localparam int unsigned TMO_W      = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chk_en,
    input  logic [N_CH-1:0]   expr,
    output logic [CH_W-1:0]   cur_ch,
    output logic              busy,
    output logic              res_valid,
    output logic [CH_W-1:0]   res_ch,
    output logic [CNT_W-1:0]  res_width,
    output logic              res_ok,
    output logic              res_short,
    output logic              res_long,
    output logic              timeout
);

    wc_state_e        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [TMO_W-1:0] tmo, tmo_n;
    logic [N_CH-1:0]  prev;
    logic [N_CH-1:0]  rise;
    logic             adv;
    logic             rep;
    logic             tmo_pulse;
    wc_result_t       rep_d;
    wc_result_t       res_q;

    assign rise = expr & ~prev;

    rr_channel_ptr #(
        .N (N_CH),
        .W (CH_W)
    ) u_ptr (
        .clk   (clk),
        .reset (reset),
        .adv   (adv),
        .ptr   (cur_ch)
    );

    // Next-state, counter and report decode.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        tmo_n     = tmo;
        adv       = 1'b0;
        rep       = 1'b0;
        tmo_pulse = 1'b0;
        rep_d     = '0;
        rep_d.ch  = WC_CH_W'(cur_ch);

        if (!chk_en) begin
            state_n = ARM;
            cnt_n   = '0;
            tmo_n   = '0;
        end else begin
            case (state)
                ARM: begin
                    if (rise[cur_ch]) begin
                        cnt_n   = CNT_W'(1);
                        tmo_n   = '0;
                        state_n = MEASURE;
                    end else if (tmo == TMO_W'(ARM_TIMEOUT - 1)) begin
                        tmo_pulse = 1'b1;
                        adv       = 1'b1;
                        tmo_n     = '0;
                    end else begin
                        tmo_n = tmo + TMO_W'(1);
                    end
                end
                MEASURE: begin
                    if (expr[cur_ch]) begin
                        if (MAX_CKS != 0 && cnt == CNT_W'(MAX_CKS)) begin
                            rep         = 1'b1;
                            rep_d.width = WC_CNT_W'(MAX_CKS + 1);
                            rep_d.long_ = 1'b1;
                            cnt_n       = '0;
                            state_n     = DRAIN;
                        end else begin
                            cnt_n = (&cnt) ? cnt : cnt + CNT_W'(1);
                        end
                    end else begin
                        rep         = 1'b1;
                        rep_d.width = WC_CNT_W'(cnt);
                        if (32'(cnt) < MIN_CKS) begin
                            rep_d.short_ = 1'b1;
                        end else begin
                            rep_d.ok = 1'b1;
                        end
                        cnt_n   = '0;
                        adv     = 1'b1;
                        state_n = ARM;
                    end
                end
                DRAIN: begin
                    if (!expr[cur_ch]) begin
                        adv     = 1'b1;
                        state_n = ARM;
                    end
                end
                default: begin
                    state_n = ARM;
                    cnt_n   = '0;
                    tmo_n   = '0;
                end
            endcase
        end
    end

    // State, counters, edge history and registered report outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARM;
            cnt       <= '0;
            tmo       <= '0;
            prev      <= '0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            timeout   <= 1'b0;
            res_q     <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            tmo       <= tmo_n;
            prev      <= expr;
            busy      <= (state_n != ARM);
            res_valid <= rep;
            timeout   <= tmo_pulse;
            if (rep) begin
                res_q <= rep_d;
            end
        end
    end

    assign res_ch    = CH_W'(res_q.ch);
    assign res_width = CNT_W'(res_q.width);
    assign res_ok    = res_q.ok;
    assign res_short = res_q.short_;
    assign res_long  = res_q.long_;

endmodule
